// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the scratch-memory arbiter.
//   MEMORY_ADDR_BITS : default memory address width
//   mem_mode_e       : encodings driven onto the memory mode pin
//   arb_state_e      : arbiter sequencing states
//   port_e           : requester identity (A = stack engine, B = host/debug loader)
package mem_arbiter_pkg;

  localparam int unsigned MEMORY_ADDR_BITS = 4;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_READ  = 2'd1,
    MODE_WRITE = 2'd2,
    MODE_CLEAR = 2'd3
  } mem_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker for the scratch-memory arbiter.
//   req_a, req_b : pending requests
//   rr_last      : port granted most recently
//   pick         : port to grant (only meaningful when a request is pending)
// Build option: MEM_ARB_FIXED_PRIORITY_EN makes A always win a tie and
// ignores rr_last; by default ties alternate round-robin.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_e rr_last,
  output port_e pick
);

  always_comb begin
    pick = PORT_A;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    if (!req_a && req_b) pick = PORT_B;
`else
    if (req_a && req_b) pick = (rr_last == PORT_A) ? PORT_B : PORT_A;
    else if (req_b)     pick = PORT_B;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port scratch memory between port A (stack
// engine) and port B (host/debug loader), plus whole-memory clears.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   a_/b_ req,we,addr,wdata       access requests (held until gnt)
//   a_/b_ gnt                     one-cycle accept pulse
//   a_/b_ rvalid, rdata           read return (rdata passes mem_rdata through)
//   clear_req / clear_done        full-memory clear request / issue pulse
//   busy                          arbiter not in IDLE
//   mem_mode/addr/wdata, mem_rdata  memory pins
// Build option: MEM_ARB_FIXED_PRIORITY_EN (see mem_arb_pick) selects fixed
// A-over-B priority instead of round-robin. Clear always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = MEMORY_ADDR_BITS,
  parameter int unsigned DATA_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] rdata,
  input  logic                 clear_req,
  output logic                 clear_done,
  output logic                 busy,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  arb_state_e           state_q, state_d;
  mem_mode_e            mode_q, mode_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic                 a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic                 clear_done_q, clear_done_d;
  logic                 busy_q, busy_d;
  port_e                rr_last_q, rr_last_d;
  logic                 rd_pend_q, rd_pend_d;   // issued command is a read
  port_e                rd_port_q, rd_port_d;   // port owning that read
  port_e                pick;

  mem_arb_pick u_pick (
    .req_a   (a_req),
    .req_b   (b_req),
    .rr_last (rr_last_q),
    .pick    (pick)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = MODE_IDLE;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    clear_done_d = 1'b0;
    rr_last_d    = rr_last_q;
    rd_pend_d    = rd_pend_q;
    rd_port_d    = rd_port_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          mode_d       = MODE_CLEAR;
          clear_done_d = 1'b1;
          rd_pend_d    = 1'b0;
          state_d      = ST_ISSUE;
        end else if (a_req || b_req) begin
          if (pick == PORT_A) begin
            addr_d    = a_addr;
            wdata_d   = a_wdata;
            mode_d    = a_we ? MODE_WRITE : MODE_READ;
            rd_pend_d = !a_we;
            a_gnt_d   = 1'b1;
          end else begin
            addr_d    = b_addr;
            wdata_d   = b_wdata;
            mode_d    = b_we ? MODE_WRITE : MODE_READ;
            rd_pend_d = !b_we;
            b_gnt_d   = 1'b1;
          end
          rd_port_d = pick;
          rr_last_d = pick;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Memory executes at the end of this cycle; a read's data appears
        // on mem_rdata next cycle, so the strobe is raised alongside it.
        if (rd_pend_q) begin
          a_rvalid_d = (rd_port_q == PORT_A);
          b_rvalid_d = (rd_port_q == PORT_B);
          state_d    = ST_RDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      rr_last_q    <= PORT_B;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= PORT_A;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      rr_last_q    <= rr_last_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
  assign mem_mode   = mode_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rdata      = mem_rdata;

endmodule
